// File: rtl/f_pc_sequencer.sv
// Fetch-stage program counter: next-PC selection, fetch-address checking,
// delay-slot tracking and a saturating count of accepted fetches.
module f_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        F_Stall,
  input  logic        D_Branch_Taken,
  input  logic [31:0] D_Branch_Target,
  input  logic        D_IsJump,
  input  logic        Req,
  input  logic        ERET,
  input  logic [31:0] EPC,
  output logic [31:0] F_PC,
  output logic        F_Valid,
  output logic [4:0]  F_ExcCode,
  output logic        F_BD,
  output logic [31:0] F_FetchCount
);

  localparam logic [31:0] IM_END  = IM_BASE + 32'(IM_WORDS * 4);
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  typedef enum logic {
    RUN,
    ERET_HOLD
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        bd, bd_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic        addr_ok;

  assign addr_ok      = (pc[1:0] == 2'b00) && (pc >= IM_BASE) && (pc < IM_END);
  assign F_PC         = pc;
  assign F_Valid      = addr_ok;
  assign F_ExcCode    = addr_ok ? 5'd0 : EXC_ADEL;
  assign F_BD         = bd;
  assign F_FetchCount = cnt;

  always_comb begin
    pc_nxt    = pc;
    bd_nxt    = bd;
    cnt_nxt   = cnt;
    state_nxt = RUN;
    if (Req) begin
      pc_nxt = EXC_PC;
      bd_nxt = 1'b0;
    end else if (ERET) begin
      pc_nxt    = EPC;
      bd_nxt    = 1'b0;
      state_nxt = ERET_HOLD;
    end else if (!F_Stall) begin
      // The branch seen during ERET_HOLD belongs to an instruction the ERET flushed.
      pc_nxt = (D_Branch_Taken && state == RUN) ? D_Branch_Target : pc + 32'd4;
      bd_nxt = D_IsJump;
    end
    if (addr_ok && !F_Stall && !Req && !ERET && cnt != '1) begin
      cnt_nxt = cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= RESET_PC;
      bd    <= 1'b0;
      cnt   <= '0;
      state <= RUN;
    end else begin
      pc    <= pc_nxt;
      bd    <= bd_nxt;
      cnt   <= cnt_nxt;
      state <= state_nxt;
    end
  end

endmodule

// File: tb/tb_f_pc_sequencer.sv
// Bench for f_pc_sequencer: directed vector table, asynchronous reset cases,
// then randomized traffic checked against a behavioural reference model.
module tb_f_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int unsigned IM_WORDS = 4096;

  logic        clk;
  logic        reset;
  logic        F_Stall;
  logic        D_Branch_Taken;
  logic [31:0] D_Branch_Target;
  logic        D_IsJump;
  logic        Req;
  logic        ERET;
  logic [31:0] EPC;
  logic [31:0] F_PC;
  logic        F_Valid;
  logic [4:0]  F_ExcCode;
  logic        F_BD;
  logic [31:0] F_FetchCount;

  int checks;
  int failures;

  f_pc_sequencer #(
    .RESET_PC(RESET_PC),
    .EXC_PC  (EXC_PC),
    .IM_BASE (IM_BASE),
    .IM_WORDS(IM_WORDS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .F_Stall        (F_Stall),
    .D_Branch_Taken (D_Branch_Taken),
    .D_Branch_Target(D_Branch_Target),
    .D_IsJump       (D_IsJump),
    .Req            (Req),
    .ERET           (ERET),
    .EPC            (EPC),
    .F_PC           (F_PC),
    .F_Valid        (F_Valid),
    .F_ExcCode      (F_ExcCode),
    .F_BD           (F_BD),
    .F_FetchCount   (F_FetchCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        stall;
    logic        taken;
    logic [31:0] tgt;
    logic        isjump;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] exp_pc;
    logic        exp_bd;
    logic        exp_valid;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic bd,
                         input logic valid, input logic [31:0] cnt);
    chk({tag, ".pc"},    F_PC, pc);
    chk({tag, ".bd"},    32'(F_BD), 32'(bd));
    chk({tag, ".valid"}, 32'(F_Valid), 32'(valid));
    chk({tag, ".exc"},   32'(F_ExcCode), valid ? 32'd0 : 32'd4);
    chk({tag, ".cnt"},   F_FetchCount, cnt);
  endtask

  task automatic drive(input logic stall, input logic taken, input logic [31:0] tgt,
                       input logic isjump, input logic req, input logic eret,
                       input logic [31:0] epc);
    F_Stall         = stall;
    D_Branch_Taken  = taken;
    D_Branch_Target = tgt;
    D_IsJump        = isjump;
    Req             = req;
    ERET            = eret;
    EPC             = epc;
  endtask

  task automatic add(input logic stall, input logic taken, input logic [31:0] tgt,
                     input logic isjump, input logic req, input logic eret,
                     input logic [31:0] epc, input logic [31:0] pc, input logic bd,
                     input logic valid, input logic [31:0] cnt);
    vec_t v;
    v = '{stall, taken, tgt, isjump, req, eret, epc, pc, bd, valid, cnt};
    vecs.push_back(v);
  endtask

  // Reference model state (updated once per rising edge).
  logic [31:0] m_pc;
  logic        m_bd;
  logic [31:0] m_cnt;
  logic        m_after_eret;

  function automatic logic legal(input logic [31:0] a);
    longint unsigned lo, hi;
    lo = longint'(IM_BASE);
    hi = lo + 4 * longint'(IM_WORDS);
    return (a % 4 == 0) && (longint'(a) >= lo) && (longint'(a) < hi);
  endfunction

  task automatic model_edge(input logic stall, input logic taken, input logic [31:0] tgt,
                            input logic isjump, input logic req, input logic eret,
                            input logic [31:0] epc);
    logic counted;
    counted = legal(m_pc) && !stall && !req && !eret;
    if (counted && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (req) begin
      m_pc = EXC_PC; m_bd = 1'b0; m_after_eret = 1'b0;
    end else if (eret) begin
      m_pc = epc; m_bd = 1'b0; m_after_eret = 1'b1;
    end else if (stall) begin
      m_after_eret = 1'b0;
    end else begin
      m_pc = (taken && !m_after_eret) ? tgt : m_pc + 32'd4;
      m_bd = isjump;
      m_after_eret = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return IM_BASE + ($urandom_range(0, IM_WORDS - 1) << 2);
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_all("reset", RESET_PC, 1'b0, 1'b1, 32'd0);
    reset = 1'b1;

    //   stall tk  tgt           jmp req eret epc            exp_pc        bd valid cnt
    add(0, 0, 0,            0, 0, 0, 0,            32'h3004,     0, 1, 1);
    add(0, 0, 0,            0, 0, 0, 0,            32'h3008,     0, 1, 2);
    add(0, 0, 0,            0, 0, 0, 0,            32'h300C,     0, 1, 3);
    add(0, 0, 0,            0, 0, 0, 0,            32'h3010,     0, 1, 4);
    add(0, 1, 32'h3100,     1, 0, 0, 0,            32'h3100,     1, 1, 5);
    add(0, 0, 0,            0, 0, 0, 0,            32'h3104,     0, 1, 6);
    add(0, 1, 32'h3020,     0, 0, 0, 0,            32'h3020,     0, 1, 7);
    add(1, 0, 0,            0, 0, 0, 0,            32'h3020,     0, 1, 7);
    add(1, 0, 0,            0, 0, 0, 0,            32'h3020,     0, 1, 7);
    add(1, 0, 0,            0, 1, 0, 0,            32'h4180,     0, 1, 7);
    add(0, 0, 0,            0, 0, 0, 0,            32'h4184,     0, 1, 8);
    add(0, 1, 32'h3300,     1, 0, 1, 32'h3200,     32'h3200,     0, 1, 8);
    add(0, 1, 32'h3300,     0, 0, 0, 0,            32'h3204,     0, 1, 9);
    add(0, 1, 32'h3002,     0, 0, 0, 0,            32'h3002,     0, 0, 10);
    add(0, 0, 0,            0, 0, 0, 0,            32'h3006,     0, 0, 10);
    add(0, 0, 0,            0, 1, 0, 0,            32'h4180,     0, 1, 10);
    add(0, 1, 32'h7000,     0, 0, 0, 0,            32'h7000,     0, 0, 11);
    add(0, 0, 0,            0, 0, 0, 0,            32'h7004,     0, 0, 11);
    add(0, 0, 0,            0, 1, 1, 32'h3200,     32'h4180,     0, 1, 11);
    add(0, 0, 0,            0, 0, 1, 32'h3300,     32'h3300,     0, 1, 11);
    add(0, 1, 32'h3500,     0, 1, 0, 0,            32'h4180,     0, 1, 11);
    add(0, 1, 32'h3500,     0, 0, 0, 0,            32'h3500,     0, 1, 12);
    add(1, 0, 0,            0, 0, 1, 32'h3400,     32'h3400,     0, 1, 12);
    add(1, 1, 32'h3600,     1, 0, 0, 0,            32'h3400,     0, 1, 12);
    add(0, 1, 32'h3600,     0, 0, 0, 0,            32'h3600,     0, 1, 13);
    add(0, 0, 0,            0, 0, 0, 0,            32'h3604,     0, 1, 14);
    add(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0,           32'hFFFF_FFFC, 0, 0, 15);
    add(0, 0, 0,            0, 0, 0, 0,            32'h0000_0000, 0, 0, 15);
    add(0, 0, 0,            0, 1, 0, 0,            32'h4180,     0, 1, 15);

    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].taken, vecs[i].tgt, vecs[i].isjump,
            vecs[i].req, vecs[i].eret, vecs[i].epc);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_bd,
              vecs[i].exp_valid, vecs[i].exp_cnt);
    end

    // Asynchronous reset mid-run, away from the clock edge.
    drive(0, 1, 32'h3400, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("pre_reset.pc", F_PC, 32'h3400);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", RESET_PC, 1'b0, 1'b1, 32'd0);
    @(posedge clk);
    #1;
    chk("reset_held.pc", F_PC, RESET_PC);
    reset = 1'b1;

    // Reset during ERET_HOLD: the following taken branch must be honoured.
    drive(0, 0, 0, 0, 0, 1, 32'h3800);
    @(posedge clk);
    #1;
    chk("eret_pre_reset.pc", F_PC, 32'h3800);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    drive(0, 1, 32'h3900, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("post_hold_reset", 32'h3900, 1'b1, 1'b1, 32'd1);

    // Randomized traffic against the reference model.
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    reset = 1'b1;
    m_pc = RESET_PC; m_bd = 1'b0; m_cnt = '0; m_after_eret = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic        s, t, j, r, e;
      logic [31:0] tg, ep;
      s  = ($urandom_range(0, 3) == 0);
      t  = ($urandom_range(0, 2) == 0);
      j  = t | ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 15) == 0);
      e  = ($urandom_range(0, 11) == 0);
      tg = rand_addr();
      ep = rand_addr();
      drive(s, t, tg, j, r, e, ep);
      @(posedge clk);
      #1;
      model_edge(s, t, tg, j, r, e, ep);
      chk_all($sformatf("rand%0d", n), m_pc, m_bd, legal(m_pc), m_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
